pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 255, the consecutive dmem_busy cycles at which mem_timeout sets.
REQ-002 The block SHALL have the following ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_src1, id_src2  in  5  source register numbers of the instruction in ID.
- id_use1, id_use2  in  1  ID instruction reads id_src1 / id_src2.
- ex_dest  in  5  destination register of the instruction in EXE.
- ex_mem_read  in  1  EXE instruction is a load.
- br_taken  in  1  branch resolved taken in EXE.
- ex_multi_start  in  1  EXE instruction is multi-cycle.
- ex_multi_cycles  in  4  total EXE cycles N of that instruction.
- dmem_busy  in  1  data memory not ready; MEM stage must hold.
- pc_en, ifid_en, idex_en, exmem_en  out  1  pipeline register load enables.
- ifid_flush, idex_flush, exmem_flush  out  1  load a bubble (all-zero control) into that register.
- state  out  2  RUN=0, MULTI=1, MEMWAIT=2.
- stall_cnt  out  16  cycles with pc_en=0, saturating.
- mem_timeout  out  1  sticky timeout error.

Function
REQ-003 Control outputs SHALL be combinational from state, counters and current inputs; state, counters and flags SHALL update on the clk edge.
REQ-004 Output profiles SHALL be:
- DEFAULT: all enables 1, all flushes 0.
- FREEZE: all enables 0, all flushes 0.
- LOADUSE: pc_en=ifid_en=0, idex_en=exmem_en=1, idex_flush=1.
- BRANCH: all enables 1, ifid_flush=idex_flush=1.
- MULTIHOLD: pc_en=ifid_en=idex_en=0, exmem_en=1, exmem_flush=1.
REQ-005 Load-use hazard SHALL be ex_mem_read=1, ex_dest!=0, and (id_use1 and id_src1==ex_dest, or id_use2 and id_src2==ex_dest); ex_dest=0 SHALL never create a hazard.
REQ-006 In RUN, profile and next state SHALL follow this priority:
- dmem_busy: FREEZE, go MEMWAIT.
- ex_multi_start with N>=2: MULTIHOLD, load cnt=N-2, go MULTI.
- br_taken: BRANCH, stay RUN.
- load-use hazard: LOADUSE, stay RUN.
- otherwise: DEFAULT.
REQ-007 ex_multi_start with N=0 or 1 SHALL be treated as a single-cycle instruction, with no MULTI entry.
REQ-008 Simultaneous ex_multi_start (N>=2) and br_taken SHALL resolve to MULTI; br_taken is re-evaluated on return to RUN.
REQ-009 In MULTI with dmem_busy=1, the block SHALL output FREEZE, hold cnt, and stay in MULTI.
REQ-010 In MULTI with dmem_busy=0 and cnt!=0, the block SHALL output MULTIHOLD and decrement cnt.
REQ-011 In MULTI with dmem_busy=0 and cnt==0, the block SHALL output DEFAULT and go RUN; total MULTIHOLD cycles SHALL equal N-1.
REQ-012 In MEMWAIT with dmem_busy=1, the block SHALL output FREEZE; with dmem_busy=0 it SHALL evaluate the REQ-006 rules that cycle, including next state.
REQ-013 wait_cnt (8 bits min., wide enough for MAX_WAIT) SHALL increment each cycle dmem_busy=1 (saturating) and clear when dmem_busy=0.
REQ-014 mem_timeout SHALL set when wait_cnt reaches MAX_WAIT and hold until rst; the block SHALL otherwise keep operating.
REQ-015 stall_cnt SHALL increment on each cycle with pc_en=0 and saturate at 16'hFFFF.
REQ-016 The illegal state value 3 SHALL go to RUN on the next edge, with DEFAULT outputs meanwhile.

Reset
REQ-017 While rst=1, outputs SHALL be DEFAULT; at the edge: state=RUN, cnt=0, wait_cnt=0, stall_cnt=0, mem_timeout=0.
REQ-018 rst SHALL override every in-progress MULTI or MEMWAIT sequence with no residual stall on the following cycle.

Verification
REQ-019 Load-use: ex_mem_read=1, ex_dest=5, id_use2=1, id_src2=5 for one cycle -> LOADUSE that cycle, stall_cnt=1; repeat with ex_dest=0 -> DEFAULT.
REQ-020 Multi-cycle: ex_multi_start=1, N=4 -> MULTIHOLD for 3 cycles, DEFAULT on the 4th, state 0->1->1->1->0.
REQ-021 Busy during MULTI: N=4, dmem_busy=1 for 2 cycles mid-sequence -> FREEZE for 2 cycles, cnt held, still exactly 3 MULTIHOLD cycles.
REQ-022 Branch priority: br_taken=1 and a load-use hazard together -> BRANCH, pc_en=1; br_taken=1 with dmem_busy=1 -> FREEZE, then BRANCH on the first non-busy cycle.
REQ-023 Timeout: MAX_WAIT=4, dmem_busy held 6 cycles -> mem_timeout rises after the 4th busy cycle and stays 1 after busy drops until rst.
REQ-024 Reset mid-MULTI: rst=1 during MULTI with cnt=2 -> next cycle state=0, DEFAULT, stall_cnt=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush enables for load-use, branch,
// multi-cycle EXE and data-memory wait, with stall accounting and timeout.
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_src1,
  input  logic [4:0] id_src2,
  input  logic       id_use1,
  input  logic       id_use2,
  input  logic [4:0] ex_dest,
  input  logic       ex_mem_read,
  input  logic       br_taken,
  input  logic       ex_multi_start,
  input  logic [3:0] ex_multi_cycles,
  input  logic       dmem_busy,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic [1:0] state,
  output logic [15:0] stall_cnt,
  output logic       mem_timeout
);

  localparam int WAIT_W =
    ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] MULTI   = 2'd1;
  localparam logic [1:0] MEMWAIT = 2'd2;

  // {pc, ifid, idex, exmem enables, ifid, idex, exmem flushes}
  localparam logic [6:0] P_DEF   = 7'b1111_000;
  localparam logic [6:0] P_FRZ   = 7'b0000_000;
  localparam logic [6:0] P_LU    = 7'b0011_010;
  localparam logic [6:0] P_BR    = 7'b1111_110;
  localparam logic [6:0] P_MHOLD = 7'b0001_001;

  logic [1:0]        state_nx;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nx;
  logic [6:0]        prof;
  logic              hazard;
  logic              multi_go;

  assign hazard = ex_mem_read && (ex_dest != 5'd0) &&
                  ((id_use1 && (id_src1 == ex_dest)) ||
                   (id_use2 && (id_src2 == ex_dest)));

  assign multi_go = ex_multi_start && (ex_multi_cycles >= 4'd2);

  always_comb begin
    prof     = P_DEF;
    state_nx = RUN;
    cnt_nx   = cnt;
    unique case (state)
      RUN, MEMWAIT: begin
        if (dmem_busy) begin
          prof     = P_FRZ;
          state_nx = MEMWAIT;
        end else if (multi_go) begin
          prof     = P_MHOLD;
          cnt_nx   = ex_multi_cycles - 4'd2;
          state_nx = MULTI;
        end else if (br_taken) begin
          prof = P_BR;
        end else if (hazard) begin
          prof = P_LU;
        end
      end
      MULTI: begin
        if (dmem_busy) begin
          prof     = P_FRZ;
          state_nx = MULTI;
        end else if (cnt != 4'd0) begin
          prof     = P_MHOLD;
          cnt_nx   = cnt - 4'd1;
          state_nx = MULTI;
        end
      end
      default: ;
    endcase
    if (rst) prof = P_DEF;
  end

  assign {pc_en, ifid_en, idex_en, exmem_en,
          ifid_flush, idex_flush, exmem_flush} = prof;

  always_comb begin
    wait_nx = '0;
    if (dmem_busy)
      wait_nx = (&wait_cnt) ? wait_cnt : wait_cnt + WAIT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      cnt         <= 4'd0;
      wait_cnt    <= '0;
      stall_cnt   <= 16'd0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      wait_cnt <= wait_nx;
      // Flag on the edge that completes the MAX_WAIT-th busy cycle.
      if (dmem_busy && (wait_nx == WAIT_W'(MAX_WAIT)))
        mem_timeout <= 1'b1;
      if (!pc_en && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: per-cycle expected outputs queued at
// stimulus time and compared just before the next rising edge.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_src1, id_src2, ex_dest;
  logic       id_use1, id_use2, ex_mem_read, br_taken;
  logic       ex_multi_start, dmem_busy;
  logic [3:0] ex_multi_cycles;
  logic       pc_en, ifid_en, idex_en, exmem_en;
  logic       ifid_flush, idex_flush, exmem_flush;
  logic [1:0] state;
  logic [15:0] stall_cnt;
  logic       mem_timeout;

  localparam logic [6:0] DEF = 7'b1111_000;
  localparam logic [6:0] FRZ = 7'b0000_000;
  localparam logic [6:0] LU  = 7'b0011_010;
  localparam logic [6:0] BR  = 7'b1111_110;
  localparam logic [6:0] MH  = 7'b0001_001;

  typedef struct packed {
    logic [6:0]  prof;
    logic [1:0]  st;
    logic [15:0] sc;
    logic        to;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  pipeline_hazard_ctrl #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2),
    .ex_dest(ex_dest), .ex_mem_read(ex_mem_read),
    .br_taken(br_taken), .ex_multi_start(ex_multi_start),
    .ex_multi_cycles(ex_multi_cycles), .dmem_busy(dmem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .state(state), .stall_cnt(stall_cnt),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set(input logic r, input logic b,
                     input logic mr, input logic [4:0] d,
                     input logic u1, input logic [4:0] s1,
                     input logic u2, input logic [4:0] s2,
                     input logic bt, input logic ms,
                     input logic [3:0] mc);
    rst = r; dmem_busy = b; ex_mem_read = mr; ex_dest = d;
    id_use1 = u1; id_src1 = s1; id_use2 = u2; id_src2 = s2;
    br_taken = bt; ex_multi_start = ms; ex_multi_cycles = mc;
  endtask

  task automatic step(input string tag, input logic [6:0] p,
                      input logic [1:0] s, input logic [15:0] c,
                      input logic t);
    exp_t e;
    q.push_back('{prof: p, st: s, sc: c, to: t});
    #2;
    e = q.pop_front();
    check({tag, ".prof"}, 32'({pc_en, ifid_en, idex_en, exmem_en,
          ifid_flush, idex_flush, exmem_flush}), 32'(e.prof));
    check({tag, ".state"}, 32'(state), 32'(e.st));
    check({tag, ".stall"}, 32'(stall_cnt), 32'(e.sc));
    check({tag, ".tmo"}, 32'(mem_timeout), 32'(e.to));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    // reset held with hazards present: outputs stay DEFAULT
    set(1, 1, 1, 5, 0, 0, 1, 5, 1, 1, 4);
    step("rst", DEF, 0, 0, 0);
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("idle", DEF, 0, 0, 0);
    set(0, 0, 1, 5, 0, 0, 1, 5, 0, 0, 0);
    step("lu_src2", LU, 0, 0, 0);
    set(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    step("lu_r0", DEF, 0, 1, 0);
    set(0, 0, 1, 7, 1, 7, 0, 0, 0, 0, 0);
    step("lu_src1", LU, 0, 1, 0);
    set(0, 0, 1, 7, 0, 7, 0, 0, 0, 0, 0);
    step("lu_nouse", DEF, 0, 2, 0);
    // N=4 multi-cycle
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    step("m4_0", MH, 0, 2, 0);
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("m4_1", MH, 1, 3, 0);
    step("m4_2", MH, 1, 4, 0);
    step("m4_3", DEF, 1, 5, 0);
    step("m4_4", DEF, 0, 5, 0);
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("m_n1", DEF, 0, 5, 0);
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("m_n0", DEF, 0, 5, 0);
    // busy in the middle of a multi-cycle op
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    step("mb_0", MH, 0, 5, 0);
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("mb_1", MH, 1, 6, 0);
    set(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("mb_frz1", FRZ, 1, 7, 0);
    step("mb_frz2", FRZ, 1, 8, 0);
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("mb_2", MH, 1, 9, 0);
    step("mb_3", DEF, 1, 10, 0);
    // branch vs load-use
    set(0, 0, 1, 5, 0, 0, 1, 5, 1, 0, 0);
    step("br_lu", BR, 0, 10, 0);
    // multi beats branch, branch seen again after return
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
    step("mbr_0", MH, 0, 10, 0);
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("mbr_1", MH, 1, 11, 0);
    step("mbr_2", DEF, 1, 12, 0);
    step("mbr_3", BR, 0, 12, 0);
    // branch while busy
    set(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("brb_frz", FRZ, 0, 12, 0);
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("brb_br", BR, 2, 13, 0);
    // timeout after four busy cycles
    set(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("to_1", FRZ, 0, 13, 0);
    step("to_2", FRZ, 2, 14, 0);
    step("to_3", FRZ, 2, 15, 0);
    step("to_4", FRZ, 2, 16, 0);
    step("to_5", FRZ, 2, 17, 1);
    step("to_6", FRZ, 2, 18, 1);
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("to_rel", DEF, 2, 19, 1);
    step("to_hold", DEF, 0, 19, 1);
    // reset during MULTI with cnt=2
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    step("rm_0", MH, 0, 19, 1);
    set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rm_rst", DEF, 1, 20, 1);
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rm_after", DEF, 0, 0, 0);
    // MEMWAIT release straight into MULTI
    set(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("wm_frz", FRZ, 0, 0, 0);
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    step("wm_mh", MH, 2, 1, 0);
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("wm_def", DEF, 1, 2, 0);
    step("wm_run", DEF, 0, 2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
